// File: rtl/wb_mips_arb.sv
// -----------------------------------------------------------------------------
// wb_mips_arb
//
// Two-master Wishbone arbiter joining the CPU's instruction-side (ICMU) and
// data-side (DCMU) master ports onto one bus master port.
//
// Grant is registered (IDLE / GNT_I / GNT_D): a new request appears on the
// bus one cycle after it is raised. Ties out of IDLE go to the side that was
// not granted last (data side after reset). A grant is held for as long as
// the granted side keeps cyc high. When it drops cyc, the other side takes
// over on the very next edge if it is waiting.
//
// A wait counter watches the granted strobe. If no ack arrives within
// TIMEOUT cycles, the arbiter answers the master itself for one cycle (ack
// with zero data), withdraws the strobe from the bus and pulses timeout_o.
//
// Parameters
//   TIMEOUT     cycles a granted strobe may wait for ack (2..65535)
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   ic_*        instruction-side slave port (from CPU ICMU)
//   dc_*        data-side slave port (from CPU DCMU)
//   wbm_*       shared bus master port
//   timeout_o   one-cycle pulse per forced termination
//   gnt_o       current grant: 00 none, 01 instruction, 10 data
// -----------------------------------------------------------------------------
module wb_mips_arb #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,

    // instruction side
    input  logic        ic_cyc_i,
    input  logic        ic_stb_i,
    input  logic [31:2] ic_addr_i,
    input  logic [2:0]  ic_cti_i,
    input  logic [1:0]  ic_bte_i,
    input  logic [3:0]  ic_sel_i,
    input  logic        ic_we_i,
    input  logic [31:0] ic_data_i,
    output logic [31:0] ic_data_o,
    output logic        ic_ack_o,

    // data side
    input  logic        dc_cyc_i,
    input  logic        dc_stb_i,
    input  logic [31:2] dc_addr_i,
    input  logic [2:0]  dc_cti_i,
    input  logic [1:0]  dc_bte_i,
    input  logic [3:0]  dc_sel_i,
    input  logic        dc_we_i,
    input  logic [31:0] dc_data_i,
    output logic [31:0] dc_data_o,
    output logic        dc_ack_o,

    // bus master
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:2] wbm_addr_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_data_o,
    input  logic [31:0] wbm_data_i,
    input  logic        wbm_ack_i,

    output logic        timeout_o,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] WAIT_MAX  = '1;

    state_t      state;
    state_t      state_nxt;
    logic        last_d;      // 1: data side was granted most recently
    logic [15:0] wait_cnt;

    logic        sel_i;
    logic        sel_d;
    logic        g_cyc;
    logic        g_stb;
    logic [31:2] g_addr;
    logic [2:0]  g_cti;
    logic [1:0]  g_bte;
    logic [3:0]  g_sel;
    logic        g_we;
    logic [31:0] g_data;
    logic        g_wait;
    logic        to_fire;
    logic        ack_any;

    // -------------------------------------------------------------------------
    // Arbitration decision for the next edge
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            GNT_I: begin
                if (!ic_cyc_i) begin
                    state_nxt = dc_cyc_i ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                if (!dc_cyc_i) begin
                    state_nxt = ic_cyc_i ? GNT_I : IDLE;
                end
            end
            default: begin
                if (ic_cyc_i && dc_cyc_i) begin
                    state_nxt = last_d ? GNT_I : GNT_D;
                end else if (dc_cyc_i) begin
                    state_nxt = GNT_D;
                end else if (ic_cyc_i) begin
                    state_nxt = GNT_I;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Grant FSM, grant history, wait counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_o    <= 2'b00;
            last_d   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            gnt_o <= state_nxt;

            if (state_nxt == GNT_D) begin
                last_d <= 1'b1;
            end else if (state_nxt == GNT_I) begin
                last_d <= 1'b0;
            end

            if (state_nxt != state || !g_wait || wbm_ack_i || to_fire) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Request mux from the granted side (all zero when idle)
    // -------------------------------------------------------------------------
    assign sel_i = (state == GNT_I);
    assign sel_d = (state == GNT_D);

    always_comb begin
        g_cyc  = 1'b0;
        g_stb  = 1'b0;
        g_addr = '0;
        g_cti  = '0;
        g_bte  = '0;
        g_sel  = '0;
        g_we   = 1'b0;
        g_data = '0;
        if (sel_i) begin
            g_cyc  = ic_cyc_i;
            g_stb  = ic_stb_i;
            g_addr = ic_addr_i;
            g_cti  = ic_cti_i;
            g_bte  = ic_bte_i;
            g_sel  = ic_sel_i;
            g_we   = ic_we_i;
            g_data = ic_data_i;
        end else if (sel_d) begin
            g_cyc  = dc_cyc_i;
            g_stb  = dc_stb_i;
            g_addr = dc_addr_i;
            g_cti  = dc_cti_i;
            g_bte  = dc_bte_i;
            g_sel  = dc_sel_i;
            g_we   = dc_we_i;
            g_data = dc_data_i;
        end
    end

    // A real ack in the last allowed cycle takes priority over the timeout.
    assign g_wait  = g_cyc & g_stb;
    assign to_fire = g_wait & ~wbm_ack_i & (wait_cnt == WAIT_LAST);
    assign ack_any = wbm_ack_i | to_fire;

    assign wbm_cyc_o  = g_cyc;
    assign wbm_stb_o  = g_stb & ~to_fire;
    assign wbm_addr_o = g_addr;
    assign wbm_cti_o  = g_cti;
    assign wbm_bte_o  = g_bte;
    assign wbm_sel_o  = g_sel;
    assign wbm_we_o   = g_we;
    assign wbm_data_o = g_data;

    assign timeout_o  = to_fire;

    // -------------------------------------------------------------------------
    // Response routing: only the granted side sees ack/data
    // -------------------------------------------------------------------------
    assign ic_ack_o  = sel_i & ack_any;
    assign dc_ack_o  = sel_d & ack_any;
    assign ic_data_o = (sel_i && !to_fire) ? wbm_data_i : '0;
    assign dc_data_o = (sel_d && !to_fire) ? wbm_data_i : '0;

endmodule
